// File: rtl/flit_eject_ni.sv
// flit_eject_ni: ejection network interface for one NoC node.
// Flits from the router's receive port are buffered in one FIFO per virtual channel.
// A two-state arbiter picks the VC to present to the consumer. Once a packet has
// started, that VC stays locked until its tail has been delivered (wormhole order).
// Each consumed flit returns one credit to the router on the following cycle.
module flit_eject_ni #(
    parameter logic [3:0]  NODE_ID  = 4'd2,
    parameter int unsigned VC_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [70:0] flit_in,
    output logic [1:0]  credit_out,
    output logic        deq_valid,
    input  logic        deq_ready,
    output logic [63:0] deq_data,
    output logic        deq_vc,
    output logic        deq_tail,
    output logic [3:0]  deq_dest,
    output logic [15:0] pkt_count,
    output logic        overflow_err,
    output logic        misroute_err
);

    localparam int unsigned PTR_W = (VC_DEPTH > 1) ? $clog2(VC_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(VC_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(VC_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(VC_DEPTH);

    typedef enum logic [0:0] {
        StIdle,
        StLock
    } arb_state_e;

    // Circular pointer advance; depth need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Incoming flit fields
    logic        in_valid;
    logic        in_tail;
    logic [3:0]  in_dest;
    logic        in_vc;
    logic [63:0] in_data;

    assign in_valid = flit_in[70];
    assign in_tail  = flit_in[69];
    assign in_dest  = flit_in[68:65];
    assign in_vc    = flit_in[64];
    assign in_data  = flit_in[63:0];

    // Per-VC FIFO storage: entry = {tail, dest, data}
    logic [68:0]      fifo_mem_q [2][VC_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q   [2];
    logic [PTR_W-1:0] rd_ptr_d   [2];
    logic [PTR_W-1:0] wr_ptr_q   [2];
    logic [PTR_W-1:0] wr_ptr_d   [2];
    logic [CNT_W-1:0] cnt_q      [2];
    logic [CNT_W-1:0] cnt_d      [2];

    logic [1:0] not_empty;
    logic [1:0] pop_vc;
    logic [1:0] push_vc;
    logic [1:0] full_after_pop;
    logic       drop;
    logic       misroute_set;

    // Arbiter state and registered outputs
    arb_state_e  state_q;
    logic        lock_vc_q;
    logic        last_vc_q;
    logic [1:0]  credit_q;
    logic [15:0] pkt_count_q;
    logic        overflow_q;
    logic        misroute_q;

    logic        sel_vc;
    logic        present;
    logic        pop;
    logic [68:0] head;

    assign not_empty[0] = (cnt_q[0] != '0);
    assign not_empty[1] = (cnt_q[1] != '0);

    // VC selection: locked VC only while a packet is in flight, else round-robin on ties
    always_comb begin
        sel_vc  = 1'b0;
        present = 1'b0;
        if (state_q == StLock) begin
            sel_vc  = lock_vc_q;
            present = not_empty[lock_vc_q];
        end else begin
            present = |not_empty;
            sel_vc  = (&not_empty) ? ~last_vc_q : ~not_empty[0];
        end
    end

    assign head = fifo_mem_q[sel_vc][rd_ptr_q[sel_vc]];
    assign pop  = present & deq_ready;

    // Presented flit; all fields forced to zero when nothing is presented
    always_comb begin
        deq_valid = present;
        deq_data  = '0;
        deq_vc    = 1'b0;
        deq_tail  = 1'b0;
        deq_dest  = '0;
        if (present) begin
            deq_data = head[63:0];
            deq_vc   = sel_vc;
            deq_tail = head[68];
            deq_dest = head[67:64];
        end
    end

    // FIFO next state; fullness is judged after a same-edge pop from the same VC
    always_comb begin
        for (int v = 0; v < 2; v++) begin
            pop_vc[v]         = pop && (sel_vc == 1'(v));
            full_after_pop[v] = (cnt_q[v] == CNT_FULL) && !pop_vc[v];
            push_vc[v]        = in_valid && (in_vc == 1'(v)) && !full_after_pop[v];
            rd_ptr_d[v]       = pop_vc[v] ? ptr_inc(rd_ptr_q[v]) : rd_ptr_q[v];
            wr_ptr_d[v]       = push_vc[v] ? ptr_inc(wr_ptr_q[v]) : wr_ptr_q[v];
            cnt_d[v]          = cnt_q[v] + CNT_W'(push_vc[v]) - CNT_W'(pop_vc[v]);
        end
        drop         = in_valid && full_after_pop[in_vc];
        misroute_set = in_valid && !full_after_pop[in_vc] && (in_dest != NODE_ID);
    end

    // FIFO pointers and occupancy; reset empties both FIFOs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int v = 0; v < 2; v++) begin
                rd_ptr_q[v] <= '0;
                wr_ptr_q[v] <= '0;
                cnt_q[v]    <= '0;
            end
        end else begin
            for (int v = 0; v < 2; v++) begin
                rd_ptr_q[v] <= rd_ptr_d[v];
                wr_ptr_q[v] <= wr_ptr_d[v];
                cnt_q[v]    <= cnt_d[v];
            end
        end
    end

    // FIFO payload storage; contents are don't-care while the slot is empty
    always_ff @(posedge CLK) begin
        for (int v = 0; v < 2; v++) begin
            if (push_vc[v]) begin
                fifo_mem_q[v][wr_ptr_q[v]] <= {in_tail, in_dest, in_data};
            end
        end
    end

    // Arbiter FSM with credit return and packet counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            lock_vc_q   <= 1'b0;
            last_vc_q   <= 1'b1;
            credit_q    <= 2'b00;
            pkt_count_q <= '0;
        end else begin
            credit_q <= pop ? {1'b1, sel_vc} : 2'b00;
            if (pop) begin
                last_vc_q <= sel_vc;
                if (head[68]) begin
                    pkt_count_q <= pkt_count_q + 16'd1;
                end
                case (state_q)
                    StIdle: begin
                        if (!head[68]) begin
                            state_q   <= StLock;
                            lock_vc_q <= sel_vc;
                        end
                    end
                    StLock: begin
                        if (head[68]) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            overflow_q <= 1'b0;
            misroute_q <= 1'b0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (misroute_set) begin
                misroute_q <= 1'b1;
            end
        end
    end

    assign credit_out   = credit_q;
    assign pkt_count    = pkt_count_q;
    assign overflow_err = overflow_q;
    assign misroute_err = misroute_q;

endmodule
